// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises to a Galois LFSR word stream,
// flags mismatched successors and tracks word, error and loss-of-lock counts.
`timescale 1ns/1ps
module lfsr_checker #(
  parameter int              N           = 9,
  parameter logic [N-1:0]    POLY        = 9'h110,
  parameter int              SYNC_WORDS  = 4,
  parameter int              LOSS_THRESH = 3,
  parameter int              CW          = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          inValid,
  input  logic [N-1:0]  inData,
  output logic          locked,
  output logic          error,
  output logic [CW-1:0] errorCount,
  output logic [CW-1:0] wordCount,
  output logic [7:0]    lossCount
);

  localparam int MW = $clog2(SYNC_WORDS + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);
  localparam logic [MW-1:0] SYNC_LAST = MW'(SYNC_WORDS - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_THRESH - 1);

  typedef enum logic [1:0] {SEEK, SYNC, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    exp_q, exp_d;
  logic [MW-1:0]   match_q, match_d;
  logic [LW-1:0]   miss_q, miss_d;
  logic            locked_q, error_q, error_d;
  logic [CW-1:0]   errc_q, errc_d, wordc_q, wordc_d;
  logic [7:0]      lossc_q, lossc_d;
  logic            hit;

  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY : '0);
  endfunction

  assign hit = (inData == exp_q);

  // NOTE: every _d gets a default before any branch so no path infers a latch.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    error_d = 1'b0;
    errc_d  = errc_q;
    wordc_d = wordc_q;
    lossc_d = lossc_q;
    if (inValid) begin
      unique case (state_q)
        SEEK: begin
          if (inData != '0) begin
            exp_d   = lfsr_next(inData);
            match_d = '0;
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (hit) begin
            exp_d = lfsr_next(inData);
            if (match_q == SYNC_LAST) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else if (inData == '0) begin
            state_d = SEEK;
          end else begin
            exp_d   = lfsr_next(inData);
            match_d = '0;
          end
        end
        LOCKED: begin
          wordc_d = (&wordc_q) ? wordc_q : wordc_q + 1'b1;
          // Free-run from the expected value so one corrupt word causes no slip.
          exp_d   = lfsr_next(exp_q);
          if (hit) begin
            miss_d = '0;
          end else begin
            error_d = 1'b1;
            errc_d  = (&errc_q) ? errc_q : errc_q + 1'b1;
            if (miss_q == LOSS_LAST) begin
              state_d = SEEK;
              miss_d  = '0;
              lossc_d = (&lossc_q) ? lossc_q : lossc_q + 1'b1;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: state_d = SEEK;
      endcase
    end
    if (clear) begin
      errc_d  = '0;
      wordc_d = '0;
      lossc_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= SEEK;
      exp_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      errc_q   <= '0;
      wordc_q  <= '0;
      lossc_q  <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= (state_d == LOCKED);
      error_q  <= error_d;
      errc_q   <= errc_d;
      wordc_q  <= wordc_d;
      lossc_q  <= lossc_d;
    end
  end

  assign locked     = locked_q;
  assign error      = error_q;
  assign errorCount = errc_q;
  assign wordCount  = wordc_q;
  assign lossCount  = lossc_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a chain-length reference model queues the
// expected outputs per cycle; a monitor pops and compares them for CW=16 and CW=4.
`timescale 1ns/1ps
module tb_lfsr_checker;

  localparam int           N           = 9;
  localparam logic [8:0]   POLY        = 9'h110;
  localparam int           SYNC_WORDS  = 4;
  localparam int           LOSS_THRESH = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [8:0]  in_data = '0;
  logic        locked, error, locked4, error4;
  logic [15:0] error_count, word_count;
  logic [3:0]  error_count4, word_count4;
  logic [7:0]  loss_count, loss_count4;

  lfsr_checker #(.N(N), .POLY(POLY), .SYNC_WORDS(SYNC_WORDS), .LOSS_THRESH(LOSS_THRESH), .CW(16)) dut (
    .clock(clock), .reset(reset), .clear(clear), .inValid(in_valid), .inData(in_data),
    .locked(locked), .error(error), .errorCount(error_count), .wordCount(word_count),
    .lossCount(loss_count));

  lfsr_checker #(.N(N), .POLY(POLY), .SYNC_WORDS(SYNC_WORDS), .LOSS_THRESH(LOSS_THRESH), .CW(4)) dut4 (
    .clock(clock), .reset(reset), .clear(clear), .inValid(in_valid), .inData(in_data),
    .locked(locked4), .error(error4), .errorCount(error_count4), .wordCount(word_count4),
    .lossCount(loss_count4));

  always #5 clock = ~clock;

  typedef struct {
    bit locked;
    bit error;
    int errc;
    int wordc;
    int lossc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: lock is described by the length of the current run of
  // chained nonzero words (0 = no seed); once locked, a free-running expectation.
  bit         m_locked;
  bit         m_error;
  int         m_run, m_miss, m_errc, m_wordc, m_lossc;
  logic [8:0] m_exp;
  logic [8:0] gen_s;

  function automatic logic [8:0] nxt(input logic [8:0] s);
    logic [8:0] r;
    r = s / 2;
    if (s % 2 == 1) r = r ^ POLY;
    return r;
  endfunction

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  function automatic logic [8:0] bad_word(input logic [8:0] avoid);
    logic [8:0] r;
    do r = 9'($urandom_range(1, 511)); while (r == avoid);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_error = 0; m_run = 0; m_miss = 0;
    m_errc = 0; m_wordc = 0; m_lossc = 0; m_exp = '0;
  endtask

  task automatic step(input bit v, input logic [8:0] d, input bit clr);
    exp_t e;
    in_valid = v;
    in_data  = d;
    clear    = clr;
    m_error  = 0;
    if (v) begin
      if (m_locked) begin
        m_wordc++;
        if (d != m_exp) begin
          m_error = 1; m_errc++; m_miss++;
        end else begin
          m_miss = 0;
        end
        m_exp = nxt(m_exp);
        if (m_miss == LOSS_THRESH) begin
          m_locked = 0; m_run = 0; m_miss = 0; m_lossc++;
        end
      end else if (d == 0) begin
        m_run = 0;
      end else begin
        m_run = (m_run > 0 && d == m_exp) ? m_run + 1 : 1;
        m_exp = nxt(d);
        if (m_run == SYNC_WORDS + 1) begin
          m_locked = 1; m_miss = 0;
        end
      end
    end
    if (clr) begin
      m_errc = 0; m_wordc = 0; m_lossc = 0;
    end
    e.locked = m_locked; e.error = m_error;
    e.errc = m_errc; e.wordc = m_wordc; e.lossc = m_lossc;
    sb_q.push_back(e);
    @(posedge clock);
    #2;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic send_clean(input int count, input int gmin, input int gmax);
    for (int i = 0; i < count; i++) begin
      if (gmax > 0) repeat ($urandom_range(gmin, gmax)) step(1'b0, 9'($urandom), 1'b0);
      step(1'b1, gen_s, 1'b0);
      gen_s = nxt(gen_s);
    end
  endtask

  task automatic send_bad(input int count);
    for (int i = 0; i < count; i++) begin
      step(1'b1, bad_word(gen_s), 1'b0);
      gen_s = nxt(gen_s);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared 1 ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("locked",      int'(locked),       int'(e.locked));
        check("error",       int'(error),        int'(e.error));
        check("errorCount",  int'(error_count),  sat(e.errc, 16));
        check("wordCount",   int'(word_count),   sat(e.wordc, 16));
        check("lossCount",   int'(loss_count),   sat(e.lossc, 8));
        check("errorCount4", int'(error_count4), sat(e.errc, 4));
        check("wordCount4",  int'(word_count4),  sat(e.wordc, 4));
        check("locked4",     int'(locked4),      int'(e.locked));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] w, one;
    int roll;
    one = 9'h001;
    model_reset();
    #1 reset = 1'b0;
    #2;
    check("rst_locked", int'(locked), 0);
    check("rst_error",  int'(error), 0);
    check("rst_errc",   int'(error_count), 0);
    check("rst_wordc",  int'(word_count), 0);
    check("rst_lossc",  int'(loss_count), 0);
    @(posedge clock); #2;
    reset = 1'b1;

    // Clean stream from seed 001: lock after the 5th word, then the full period.
    gen_s = 9'h001;
    send_clean(4, 0, 0);
    check("lock_after4", int'(locked), 0);
    send_clean(1, 0, 0);
    check("lock_after5", int'(locked), 1);
    send_clean(506, 0, 0);
    check("period_wordc", int'(word_count), 506);
    check("period_errc",  int'(error_count), 0);
    send_clean(1, 0, 0);

    // Single-bit corruption while locked.
    step(1'b1, gen_s ^ 9'h008, 1'b0);
    gen_s = nxt(gen_s);
    check("corrupt_error", int'(error), 1);
    send_clean(10, 0, 0);
    check("corrupt_errc",   int'(error_count), 1);
    check("corrupt_locked", int'(locked), 1);

    // Loss of lock after three bad words, then relock.
    step(1'b0, 9'h000, 1'b1);
    send_bad(3);
    check("loss_locked", int'(locked), 0);
    check("loss_errc",   int'(error_count), 3);
    check("loss_lossc",  int'(loss_count), 1);
    gen_s = bad_word(9'h000);
    send_clean(4, 0, 0);
    check("relock_after4", int'(locked), 0);
    send_clean(1, 0, 0);
    check("relock_after5", int'(locked), 1);

    // Gaps of 1..7 idle cycles, then a zero word while locked.
    send_clean(40, 1, 7);
    step(1'b1, 9'h000, 1'b0);
    gen_s = nxt(gen_s);
    check("zero_locked_error", int'(error), 1);
    send_clean(5, 0, 0);

    // SYNC reseed: seed, wrong word, then a stream continuing from the wrong word.
    send_bad(3);
    step(1'b1, gen_s, 1'b0);
    w = bad_word(nxt(gen_s));
    gen_s = w;
    send_clean(4, 0, 0);
    check("reseed_after4", int'(locked), 0);
    send_clean(1, 0, 0);
    check("reseed_after5", int'(locked), 1);

    // Clear coincident with an error.
    step(1'b1, gen_s ^ 9'h008, 1'b1);
    gen_s = nxt(gen_s);
    check("clr_err_pulse", int'(error), 1);
    check("clr_err_errc",  int'(error_count), 0);

    // Twenty isolated errors saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, gen_s ^ (one << $urandom_range(0, 8)), 1'b0);
      gen_s = nxt(gen_s);
      send_clean(1, 0, 0);
    end
    check("sat_errc16", int'(error_count), 20);
    check("sat_errc4",  int'(error_count4), 15);

    // Asynchronous reset between edges, zero words in SEEK, reacquire.
    #1 reset = 1'b0;
    #1;
    check("async_locked", int'(locked), 0);
    check("async_errc",   int'(error_count), 0);
    check("async_wordc",  int'(word_count), 0);
    check("async_lossc",  int'(loss_count), 0);
    model_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    repeat (3) step(1'b1, 9'h000, 1'b0);
    check("seek_zero_locked", int'(locked), 0);
    gen_s = bad_word(9'h000);
    send_clean(5, 0, 0);
    check("post_reset_lock", int'(locked), 1);

    // Randomised traffic: gaps, corruptions, zeros, bursts, clears.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 7)) step(1'b0, 9'($urandom), 1'b0);
      roll = $urandom_range(0, 63);
      if (roll < 4) begin
        step(1'b1, gen_s ^ (one << $urandom_range(0, 8)), 1'b0);
        gen_s = nxt(gen_s);
      end else if (roll == 4) begin
        step(1'b1, 9'h000, 1'b0);
        gen_s = nxt(gen_s);
      end else if (roll == 5) begin
        send_bad(3);
      end else begin
        step(1'b1, gen_s, roll == 6);
        gen_s = nxt(gen_s);
      end
    end

    @(posedge clock); #3;
    check("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Receive-side companion to LFSR: consumes a stream of N-bit words that should be successive states of a maximal-length Galois LFSR and checks that each word is the correct successor of the previous one.
- Self-synchronises from the received data, so it needs no shared seed.
- Counts words and mismatches, and detects loss of lock.
- Used for on-chip PRBS checking of datapaths, FIFOs and links that carry LFSR-generated test traffic.

Parameters:
- N, 9, word width and LFSR degree.
- POLY, 9'h110, Galois tap mask; must equal the polynomial used by the generating LFSR of width N.
- SYNC_WORDS, 4, consecutive correct successors required to declare lock.
- LOSS_THRESH, 3, consecutive mismatches while locked that drop lock.
- CW, 16, width of the word and error counters.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of all counters; does not affect lock state.
- inValid  input  1  inData carries a word this cycle; there is no backpressure.
- inData  input  N  received word.
- locked  output  1  checker is in LOCKED.
- error  output  1  one-cycle pulse: the previous-cycle word mismatched while LOCKED.
- errorCount  output  CW  mismatches counted while LOCKED; saturating.
- wordCount  output  CW  valid words consumed while LOCKED; saturating.
- lossCount  output  8  number of LOCKED->SEEK transitions; saturating.

Behaviour:
- Step function: next(s) = (s >> 1) ^ (s[0] ? POLY : 0). Computed combinationally on N bits, no width growth.
- Reset (reset=0, async): state=SEEK, expected=0, match and miss counters=0. Outputs locked=0, error=0, errorCount=0, wordCount=0, lossCount=0.
- All outputs are registered. A word sampled at edge k affects outputs visible after edge k.
- Cycles with inValid=0 change nothing; error=0 in those cycles.
- SEEK:
  - On valid with inData!=0: expected<=next(inData), matchCnt<=0, go to SYNC.
  - On valid with inData==0: this is the illegal LFSR state; ignore it and stay in SEEK.
- SYNC:
  - On valid with inData==expected: matchCnt++, expected<=next(inData). When matchCnt reaches SYNC_WORDS, go to LOCKED with missCnt=0 and locked=1.
  - On valid mismatch: reseed from inData exactly as in SEEK. A zero word returns to SEEK. error is never pulsed in SYNC.
- LOCKED, on every valid word:
  - wordCount++ (saturating).
  - expected<=next(expected). Advance from the expected value, not the received one, so an isolated corrupt word causes no slip.
  - On match: missCnt<=0.
  - On mismatch (including inData==0): error=1 next cycle, errorCount++ (saturating), missCnt++.
  - When missCnt reaches LOSS_THRESH: go to SEEK, locked=0, lossCount++ (saturating). The word that triggers loss is itself counted in errorCount.
- clear together with a counted event in the same cycle: clear wins; counters read 0.
- Saturation: counters stick at all-ones and never wrap.
- Asserting reset mid-stream immediately forces the reset values; after release the checker reacquires from SEEK.
- Lock latency from a clean stream: the first word seeds, then SYNC_WORDS words confirm. locked rises after the (SYNC_WORDS+1)th valid word.

Test Plan:
- Clean stream: defaults, words from seed 9'h001 (001,110,088,044,022,...), one per cycle.
  - locked rises after the 5th word.
  - Run the full period: after 511 steps the stream returns to 9'h001, with errorCount=0 and wordCount=506.
- Single-word corruption while locked: flip bit 3 of one word.
  - error pulses once, errorCount=1, locked stays 1.
  - Following correct words produce no further errors.
- Loss of lock: after lock, send 3 random nonzero non-matching words.
  - error pulses 3 times, errorCount=3, locked falls after the 3rd, lossCount=1.
  - Resume a valid stream from any state: relock after 5 words.
- Zero and gap handling: inValid gaps of 1–7 cycles in the stream cause no errors and no counter changes. A 9'h000 word in SEEK is ignored; a 9'h000 word in LOCKED counts as a mismatch.
- SYNC reseed: send seed, one wrong word, then a correct stream continuing from that wrong word. No error pulses, and locked rises 4 words after the wrong word.
- Reset and clear:
  - Async reset asserted mid-stream, between clock edges, clears outputs immediately.
  - With CW=4, 20 errors saturate errorCount at 4'hF.
  - clear coincident with an error leaves errorCount=0.
